// File: rtl/div_unit_if.sv
// Handshake and result bundle between the execute stage and the divider.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               cancel;
  logic               busy;
  logic               stall_req;
  logic               done;
  logic               div_by_zero;
  logic [2*WIDTH-1:0] hilo_o;

  // Execute stage side: issues requests, consumes results.
  modport master (
    output start, signed_div, dividend, divisor, cancel,
    input  busy, stall_req, done, div_by_zero, hilo_o
  );

  // Divider side.
  modport slave (
    input  start, signed_div, dividend, divisor, cancel,
    output busy, stall_req, done, div_by_zero, hilo_o
  );

endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvsr;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [2*WIDTH-1:0] r_hilo;

  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Operand magnitudes; the most negative value maps onto itself, which is the correct unsigned magnitude.
  assign w_dvd_neg = bus.signed_div & bus.dividend[WIDTH-1];
  assign w_dvs_neg = bus.signed_div & bus.divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
  assign w_dvs_mag = w_dvs_neg ? (~bus.divisor + WIDTH'(1)) : bus.divisor;

  // One restoring step: shift next dividend bit into the partial remainder and trial-subtract.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvsr};

  // Sign fix-up applied when the result is committed.
  assign w_quo_fix = r_neg_q ? (~r_quo + WIDTH'(1)) : r_quo;
  assign w_rem_fix = r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hilo  <= '0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      if (bus.cancel) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_cnt <= '0;
              if (bus.divisor == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_dbz   <= 1'b1;
                r_hilo  <= {bus.dividend, {WIDTH{1'b1}}};
              end else begin
                r_state <= S_BUSY;
                r_busy  <= 1'b1;
                r_rem   <= '0;
                r_quo   <= w_dvd_mag;
                r_dvsr  <= w_dvs_mag;
                r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                r_neg_r <= w_dvd_neg;
              end
            end
          end
          S_BUSY: begin
            if (r_cnt == CNT_W'(WIDTH)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_cnt   <= '0;
              r_hilo  <= {w_rem_fix, w_quo_fix};
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (!w_diff[WIDTH]) begin
                r_rem <= w_diff[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
              end else begin
                r_rem <= w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Stall is combinational so the accepting instruction holds in the same cycle; released in DONE.
  assign bus.stall_req   = ((r_state == S_IDLE) & bus.start & ~bus.cancel) | (r_state == S_BUSY);
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hilo_o      = r_hilo;

endmodule
